// File: rtl/ethernet_mmio_arbiter_pkg.sv
// Shared types for the ethernet MMIO arbiter: FSM states, the latched
// request bundle and the access alignment check.
package ethernet_mmio_arbiter_pkg;

  localparam int mmio_data_width_lp = 32;
  localparam int mmio_addr_width_lp = 14;
  localparam int mmio_size_width_lp = 2;
  localparam int mmio_id_width_lp   = 4;

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_capture,
    e_resp
  } arb_state_e;

  typedef logic [mmio_data_width_lp-1:0] mmio_data_t;
  typedef logic [mmio_addr_width_lp-1:0] mmio_addr_t;
  typedef logic [mmio_size_width_lp-1:0] mmio_size_t;
  typedef logic [mmio_id_width_lp-1:0]   mmio_id_t;

  typedef struct packed {
    logic       we;
    mmio_addr_t addr;
    mmio_size_t size;
    mmio_data_t data;
    mmio_id_t   id;
  } mmio_req_s;

  // Wider than the bus, or address not a multiple of the access size.
  function automatic logic misaligned(
    input mmio_addr_t addr,
    input mmio_size_t size,
    input int         lg_max
  );
    mmio_addr_t mask;
    mask = (mmio_addr_t'(1) << size) - mmio_addr_t'(1);
    return (int'(size) > lg_max) || ((addr & mask) != '0);
  endfunction

endpackage

// File: rtl/ethernet_mmio_arbiter_rr.sv
// Round-robin grant selection; the search starts at the pointer and the
// pointer moves past the winner only when the grant is consumed.
module bsg_arb_round_robin
  import ethernet_mmio_arbiter_pkg::*;
#(
  parameter int num_p = 2,
  localparam int tag_width_lp = (num_p > 1) ? $clog2(num_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_p-1:0]        reqs_i,
  output logic [num_p-1:0]        grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    v_o,
  input  logic                    yumi_i
);

  logic [tag_width_lp-1:0] ptr_r;

  always_comb begin
    v_o   = 1'b0;
    tag_o = '0;
    for (int k = 0; k < num_p; k++) begin
      if (!v_o && reqs_i[(int'(ptr_r) + k) % num_p]) begin
        v_o   = 1'b1;
        tag_o = tag_width_lp'((int'(ptr_r) + k) % num_p);
      end
    end
  end

  assign grants_o = v_o ? (num_p'(1) << tag_o) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (yumi_i && v_o) begin
      if (int'(tag_o) == num_p - 1) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= tag_o + tag_width_lp'(1);
      end
    end
  end

endmodule

// File: rtl/ethernet_mmio_arbiter.sv
// Shares the ethernet controller MMIO port among several requesters,
// one transaction at a time, returning each result on a valid/yumi channel.
module ethernet_mmio_arbiter
  import ethernet_mmio_arbiter_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int num_req_p    = 2,
  localparam int size_width_lp =
    $clog2(((data_width_p / 8 == 1) ? 1 : $clog2(data_width_p / 8)) + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p-1:0]              req_we_i,
  input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p*size_width_lp-1:0] req_size_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              resp_v_o,
  input  logic [num_req_p-1:0]              resp_yumi_i,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic                              resp_err_o,
  output logic [addr_width_p-1:0]           addr_o,
  output logic                              write_en_o,
  output logic                              read_en_o,
  output logic [size_width_lp-1:0]          op_size_o,
  output logic [data_width_p-1:0]           write_data_o,
  input  logic [data_width_p-1:0]           read_data_i
);

  localparam int lg_bytes_lp  = $clog2(data_width_p / 8);
  localparam int tag_width_lp = $clog2(num_req_p);

  arb_state_e state_r;
  mmio_req_s  req_q;
  mmio_req_s  req_sel;

  logic [num_req_p-1:0]    grants;
  logic [tag_width_lp-1:0] tag;
  logic                    arb_v;
  logic                    accept;
  logic                    bad;

  assign accept = (state_r == e_idle) && arb_v;

  bsg_arb_round_robin #(
    .num_p (num_req_p)
  ) rr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (req_v_i),
    .grants_o (grants),
    .tag_o    (tag),
    .v_o      (arb_v),
    .yumi_i   (accept)
  );

  always_comb begin
    req_sel      = '0;
    req_sel.we   = req_we_i[tag];
    req_sel.addr = mmio_addr_t'(req_addr_i[tag*addr_width_p +: addr_width_p]);
    req_sel.size = mmio_size_t'(req_size_i[tag*size_width_lp +: size_width_lp]);
    req_sel.data = mmio_data_t'(req_data_i[tag*data_width_p +: data_width_p]);
    req_sel.id   = mmio_id_t'(tag);
  end

  assign bad = misaligned(req_sel.addr, req_sel.size, lg_bytes_lp);

  assign req_ready_o  = (state_r == e_idle) ? grants : '0;
  assign addr_o       = addr_width_p'(req_q.addr);
  assign op_size_o    = size_width_lp'(req_q.size);
  assign write_data_o = data_width_p'(req_q.data);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      req_q       <= '0;
      write_en_o  <= 1'b0;
      read_en_o   <= 1'b0;
      resp_v_o    <= '0;
      resp_data_o <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      write_en_o <= 1'b0;
      read_en_o  <= 1'b0;
      unique case (state_r)
        e_idle: begin
          if (accept) begin
            req_q.we <= req_sel.we;
            req_q.id <= req_sel.id;
            if (bad) begin
              // Rejected without touching the controller pins.
              state_r     <= e_resp;
              resp_v_o    <= grants;
              resp_err_o  <= 1'b1;
              resp_data_o <= '0;
            end else begin
              state_r      <= e_issue;
              req_q.addr   <= req_sel.addr;
              req_q.size   <= req_sel.size;
              req_q.data   <= req_sel.data;
              write_en_o   <= req_sel.we;
              read_en_o    <= !req_sel.we;
            end
          end
        end
        e_issue: begin
          if (req_q.we) begin
            state_r     <= e_resp;
            resp_v_o    <= num_req_p'(1) << req_q.id;
            resp_err_o  <= 1'b0;
            resp_data_o <= '0;
          end else begin
            state_r <= e_capture;
          end
        end
        e_capture: begin
          state_r     <= e_resp;
          resp_v_o    <= num_req_p'(1) << req_q.id;
          resp_err_o  <= 1'b0;
          resp_data_o <= read_data_i;
        end
        e_resp: begin
          if ((resp_v_o & resp_yumi_i) != '0) begin
            state_r  <= e_idle;
            resp_v_o <= '0;
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Scoreboard bench for the MMIO arbiter with a behavioural controller
// memory behind the MMIO pins.
module tb_ethernet_mmio_arbiter;

  logic        clk;
  logic        reset_i;
  logic [1:0]  req_v_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_we_i;
  logic [27:0] req_addr_i;
  logic [3:0]  req_size_i;
  logic [63:0] req_data_i;
  logic [1:0]  resp_v_o;
  logic [1:0]  resp_yumi_i;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;

  logic        r_v    [2];
  logic        r_we   [2];
  logic [13:0] r_addr [2];
  logic [1:0]  r_size [2];
  logic [31:0] r_data [2];
  logic        yumi_en;
  logic [1:0]  stray;

  assign req_v_i     = {r_v[1], r_v[0]};
  assign req_we_i    = {r_we[1], r_we[0]};
  assign req_addr_i  = {r_addr[1], r_addr[0]};
  assign req_size_i  = {r_size[1], r_size[0]};
  assign req_data_i  = {r_data[1], r_data[0]};
  assign resp_yumi_i = (resp_v_o & {2{yumi_en}}) | stray;

  ethernet_mmio_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_v_i      (req_v_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_size_i   (req_size_i),
    .req_data_i   (req_data_i),
    .resp_v_o     (resp_v_o),
    .resp_yumi_i  (resp_yumi_i),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .addr_o       (addr_o),
    .write_en_o   (write_en_o),
    .read_en_o    (read_en_o),
    .op_size_o    (op_size_o),
    .write_data_o (write_data_o),
    .read_data_i  (read_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    return 2'(1 << i);
  endfunction

  // Controller model: synchronous read, data valid the cycle after read_en.
  logic [31:0] mem [int];

  function automatic logic [31:0] rd(input logic [13:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {16'h5A5A, 2'b00, a};
  endfunction

  always @(posedge clk) begin
    if (write_en_o) mem[int'(addr_o)] = write_data_o;
    read_data_i <= read_en_o ? rd(addr_o) : 32'hBAD0_BAD0;
  end

  typedef struct {
    int          id;
    bit          we;
    logic [13:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int id, input bit we, input logic [13:0] a,
                      input logic [1:0] s, input logic [31:0] wd,
                      input logic [31:0] rdat, input bit err);
    exp_t e;
    e.id = id; e.we = we; e.addr = a; e.size = s; e.wdata = wd;
    e.err = err;
    e.rdata = (err || we) ? 32'h0 : rdat;
    e.lat = err ? 1 : (we ? 2 : 3);
    exp_q.push_back(e);
  endtask

  // Monitor: tracks the single in-flight transaction against the queue.
  exp_t        cur;
  bit          cur_v = 0;
  bit          resp_seen = 0;
  int          t_acc = 0;
  int          last_strobe = -100;
  logic [31:0] held_data;

  always @(negedge clk) begin
    if (reset_i) begin
      cur_v     = 0;
      resp_seen = 0;
    end else begin
      if (write_en_o || read_en_o) begin
        chk("strobe_single", 32'(write_en_o & read_en_o), 0);
        chk("strobe_spacing", 32'(cyc - last_strobe >= 3), 1);
        last_strobe = cyc;
        chk("strobe_expected", 32'(cur_v && !cur.err), 1);
        if (cur_v) begin
          chk("strobe_time", cyc - t_acc, 1);
          chk("strobe_we", 32'(write_en_o), 32'(cur.we));
          chk("strobe_addr", 32'(addr_o), 32'(cur.addr));
          chk("strobe_size", 32'(op_size_o), 32'(cur.size));
          if (cur.we) chk("strobe_wdata", write_data_o, cur.wdata);
        end
      end
      if (resp_seen) begin
        chk("resp_hold_v", 32'(resp_v_o), 32'(onehot(cur.id)));
        chk("resp_hold_data", resp_data_o, held_data);
        chk("ready_in_resp", 32'(req_ready_o), 0);
      end else if (resp_v_o != 2'b00) begin
        chk("resp_expected", 32'(cur_v), 1);
        if (cur_v) begin
          resp_seen = 1;
          held_data = resp_data_o;
          chk("resp_id", 32'(resp_v_o), 32'(onehot(cur.id)));
          chk("resp_latency", cyc - t_acc, cur.lat);
          chk("resp_data", resp_data_o, cur.rdata);
          chk("resp_err", 32'(resp_err_o), 32'(cur.err));
        end
      end else if (cur_v) begin
        chk("ready_busy", 32'(req_ready_o), 0);
      end
      if (resp_seen && (resp_v_o & resp_yumi_i) != 2'b00) begin
        cur_v     = 0;
        resp_seen = 0;
      end
      if ((req_ready_o & req_v_i) != 2'b00) begin
        chk("accept_idle", 32'(cur_v), 0);
        chk("accept_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur   = exp_q.pop_front();
          cur_v = 1;
          t_acc = cyc;
          chk("grant_id", 32'(req_ready_o), 32'(onehot(cur.id)));
        end
      end
    end
  end

  task automatic set_req(input int i, input bit we, input logic [13:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    r_we[i] = we; r_addr[i] = a; r_size[i] = s; r_data[i] = d;
    r_v[i] = 1'b1;
  endtask

  task automatic wait_acc(input int i);
    bit got = 0;
    int n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (req_ready_o[i]) got = 1;
      n++;
    end
    chk($sformatf("accept_timeout_%0d", i), 32'(got), 1);
    @(posedge clk); #1;
  endtask

  task automatic drive(input int i, input bit we, input logic [13:0] a,
                       input logic [1:0] s, input logic [31:0] d,
                       input bit keep);
    set_req(i, we, a, s, d);
    wait_acc(i);
    if (!keep) r_v[i] = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_v[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_size[i] = '0;
      r_data[i] = '0;
    end
    yumi_en = 1'b1;
    stray   = 2'b00;
    reset_i = 1'b1;
    mem[32'h0010] = 32'hDEAD_BEEF;
    mem[32'h0014] = 32'hCAFE_F00D;
    mem[32'h0020] = 32'h0BAD_CAFE;
    mem[32'h0100] = 32'h1111_0000;
    mem[32'h0104] = 32'h1111_0001;
    mem[32'h0108] = 32'h1111_0002;
    mem[32'h010C] = 32'h1111_0003;

    settle(3);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_resp_v", 32'(resp_v_o), 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_err", 32'(resp_err_o), 0);
    chk("rst_strobes", 32'({write_en_o, read_en_o}), 0);
    chk("rst_addr", 32'(addr_o), 0);
    chk("rst_wdata", write_data_o, 0);
    chk("rst_size", 32'(op_size_o), 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    settle(2);

    // Single read, then single write.
    push(0, 0, 14'h0010, 2'd2, 32'h0, 32'hDEAD_BEEF, 0);
    drive(0, 0, 14'h0010, 2'd2, 32'h0, 0);
    settle(4);
    push(1, 1, 14'h0804, 2'd2, 32'h1234_5678, 32'h0, 0);
    drive(1, 1, 14'h0804, 2'd2, 32'h1234_5678, 0);
    settle(4);

    // Contention: both requesters valid throughout, grants must alternate.
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 14'(14'h0100 + 4 * k), 2'd2, 32'h0,
           32'(32'h1111_0000 + k), 0);
      push(1, 1, 14'(14'h0200 + 4 * k), 2'd2,
           32'(32'hA000_0000 + k), 32'h0, 0);
    end
    fork
      for (int k = 0; k < 4; k++)
        drive(0, 0, 14'(14'h0100 + 4 * k), 2'd2, 32'h0, k < 3);
      for (int k = 0; k < 4; k++)
        drive(1, 1, 14'(14'h0200 + 4 * k), 2'd2,
              32'(32'hA000_0000 + k), k < 3);
    join
    settle(5);

    // Misaligned halfword, oversize access, legal odd-address byte read.
    push(0, 0, 14'h0003, 2'd1, 32'h0, 32'h0, 1);
    drive(0, 0, 14'h0003, 2'd1, 32'h0, 0);
    settle(3);
    push(1, 0, 14'h0008, 2'd3, 32'h0, 32'h0, 1);
    drive(1, 0, 14'h0008, 2'd3, 32'h0, 0);
    settle(3);
    push(1, 0, 14'h0011, 2'd0, 32'h0, 32'h5A5A_0011, 0);
    drive(1, 0, 14'h0011, 2'd0, 32'h0, 0);
    settle(4);

    // Backpressure: response held while another requester waits.
    yumi_en = 1'b0;
    stray   = 2'b10;
    push(0, 0, 14'h0014, 2'd2, 32'h0, 32'hCAFE_F00D, 0);
    push(1, 1, 14'h0300, 2'd2, 32'h5555_AAAA, 32'h0, 0);
    drive(0, 0, 14'h0014, 2'd2, 32'h0, 0);
    set_req(1, 1, 14'h0300, 2'd2, 32'h5555_AAAA);
    settle(7);
    stray   = 2'b00;
    yumi_en = 1'b1;
    wait_acc(1);
    r_v[1] = 1'b0;
    settle(4);

    // Reset while the read sits in e_capture.
    push(0, 0, 14'h0020, 2'd2, 32'h0, 32'h0BAD_CAFE, 0);
    drive(0, 0, 14'h0020, 2'd2, 32'h0, 0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_strobes", 32'({write_en_o, read_en_o}), 0);
    chk("post_rst_resp_v", 32'(resp_v_o), 0);
    chk("post_rst_ready", 32'(req_ready_o), 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    push(0, 0, 14'h0010, 2'd2, 32'h0, 32'hDEAD_BEEF, 0);
    push(1, 1, 14'h0400, 2'd2, 32'h0F0F_0F0F, 32'h0, 0);
    fork
      drive(0, 0, 14'h0010, 2'd2, 32'h0, 0);
      drive(1, 1, 14'h0400, 2'd2, 32'h0F0F_0F0F, 0);
    join
    settle(8);

    chk("sb_drained", exp_q.size(), 0);
    chk("idle_at_end", 32'(cur_v), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_mmio_arbiter.md
Name: ethernet_mmio_arbiter

Overview:
- Shares the single synchronous-read MMIO port of ethernet_controller_wrapper between num_req_p requesters, for example the core CSR path and a debug/host bridge.
- Grants are round-robin, with one transaction in flight at a time.
- Read data from the controller is captured, and every transaction (read or write) is returned to its requester through a valid/yumi response channel.
- Sits between the requester-side crossbar and the ethernet_controller_wrapper MMIO pins, in the clk_i domain.

Parameters:
- data_width_p, 32, MMIO data width; must match the controller.
- addr_width_p, 14, MMIO byte address width.
- num_req_p, 2, number of requesters; minimum 2.
- size_width_lp (local), `BSG_WIDTH(`BSG_SAFE_CLOG2(data_width_p/8)), width of the log2 byte-size field.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  num_req_p  per-requester request valid.
- req_ready_o  out  num_req_p  per-requester accept; one-hot or zero.
- req_we_i  in  num_req_p  1 = write, 0 = read.
- req_addr_i  in  num_req_p x addr_width_p  byte address.
- req_size_i  in  num_req_p x size_width_lp  log2 bytes.
- req_data_i  in  num_req_p x data_width_p  write data.
- resp_v_o  out  num_req_p  response valid; one-hot or zero.
- resp_yumi_i  in  num_req_p  response consumed.
- resp_data_o  out  data_width_p  read data; shared by all requesters.
- resp_err_o  out  1  misaligned-access error flag.
- addr_o  out  addr_width_p  to controller addr_i.
- write_en_o  out  1  to controller write_en_i.
- read_en_o  out  1  to controller read_en_i.
- op_size_o  out  size_width_lp  to controller op_size_i.
- write_data_o  out  data_width_p  to controller write_data_i.
- read_data_i  in  data_width_p  from controller read_data_o; valid the cycle after read_en_o.

Behaviour:
- Reset values:
  - All outputs to the controller are 0.
  - req_ready_o = 0, resp_v_o = 0, resp_data_o = 0, resp_err_o = 0.
  - FSM is in e_idle; round-robin pointer = 0.
- FSM states: e_idle, e_issue, e_capture, e_resp.
- e_idle:
  - The round-robin arbiter picks g among the set bits of req_v_i, starting at the pointer.
  - req_ready_o[g] = 1 combinationally; the request fields are latched into internal registers.
  - The pointer advances to g+1 mod num_req_p.
  - Misaligned request (req_addr_i mod 2^req_size_i != 0, or req_size_i > log2(data_width_p/8)): go to e_resp with err = 1 and data = 0. The controller is never strobed.
  - Otherwise go to e_issue.
  - With no request valid, the FSM stays in e_idle and the pointer is unchanged.
- e_issue:
  - addr_o, op_size_o and write_data_o are driven from the latched registers.
  - Exactly one of write_en_o or read_en_o is 1, for exactly this one cycle.
  - Write: go to e_resp with data = 0, err = 0. Read: go to e_capture.
- e_capture: read_data_i is registered into the response buffer; go to e_resp.
- e_resp:
  - resp_v_o[g] = 1 and the buffer is held stable until resp_yumi_i[g].
  - On yumi, go to e_idle on the same edge.
- Strobes are 0 in every state other than e_issue. addr_o, op_size_o and write_data_o hold their last value between transactions.
- Latency, counted from the accept cycle T:
  - Strobe at T+1.
  - Write: resp_v_o at T+2.
  - Read: data sampled at T+2, resp_v_o at T+3.
  - Misaligned: resp_v_o at T+1.
- Throughput: the next accept can occur the cycle after the yumi cycle.
- req_ready_o is 0 in every state other than e_idle. Requesters must hold req_* stable while req_v_i is high and not accepted.
- resp_yumi_i is ignored unless resp_v_o of the same index is high. A yumi to a non-granted index has no effect.
- Simultaneous valid requests are served in round-robin order; starvation is impossible.
- Reset asserted mid-transaction:
  - Return to e_idle and abort any pending response.
  - Strobes drop on the same edge; a strobe never lasts past the reset edge.

Decomposition:
- ethernet_mmio_arbiter_pkg holds:
  - the state enum (e_idle, e_issue, e_capture, e_resp);
  - a packed request struct {we, addr, size, data, id};
  - the alignment-check function.
- Sub-module: bsg_arb_round_robin provides grant selection, with yumi driven from the e_idle accept.

Test Plan:
- Single read: req0 reads addr 0x0010, size 2, controller returns 0xDEADBEEF.
  - Required: read_en_o only at T+1 with addr_o = 0x0010, resp_v_o[0] at T+3, resp_data_o = 0xDEADBEEF.
- Single write: req1 writes 0x12345678 to 0x0804, size 2.
  - Required: write_en_o one cycle with write_data_o = 0x12345678, resp_v_o[1] at T+2, err = 0.
- Contention: req0 and req1 both valid continuously, performing 4 transactions each.
  - Required: grants alternate 0,1,0,1…; never two strobes closer than 3 cycles.
- Misaligned: req0 reads addr 0x0003 with size 1.
  - Required: no strobe, resp_v_o[0] at T+1, resp_err_o = 1, resp_data_o = 0.
- Backpressure: resp_yumi_i held low for 5 cycles after a read response.
  - Required: resp_data_o stable, req_ready_o = 0 throughout, no new strobe.
- Reset during e_capture: reset_i pulsed.
  - Required: next cycle all strobes, resp_v_o and req_ready_o = 0, FSM in e_idle; a fresh request after reset is granted from index 0.
